// File: rtl/slm_bank_access_ctrl.sv
// Initiator-side controller for a shared-local-memory bank: registers client
// write/read requests onto the bank's write (port 0) and read (port 1) pins,
// stalls same-address same-cycle reads behind writes, and buffers read data
// in a credit-protected response FIFO.
module slm_bank_access_ctrl #(
    parameter int ADDR_W    = 17,
    parameter int DATA_W    = 64,
    parameter int RSP_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] wr_mask,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              CE0,
    output logic [ADDR_W-1:0] A0,
    output logic [DATA_W-1:0] D0,
    output logic              WE0,
    output logic [DATA_W-1:0] WEM0,
    output logic              CE1,
    output logic [ADDR_W-1:0] A1,
    input  logic [DATA_W-1:0] Q1,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_FW = $clog2(RSP_DEPTH + 1);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(RSP_DEPTH - 1);
    localparam logic [CNT_FW-1:0] FULL_CNT = CNT_FW'(RSP_DEPTH);
    localparam logic [CNT_FW:0]   DEPTH_V  = (CNT_FW + 1)'(RSP_DEPTH);

    // Saturating increment for the hazard counter
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Pointer advance with explicit wrap so non-power-of-2 depths work
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    logic                r_ce0_p1, r_we0_p1;
    logic [ADDR_W-1:0]   r_a0_p1;
    logic [DATA_W-1:0]   r_d0_p1, r_wem0_p1;
    logic                r_ce1_p1;
    logic [ADDR_W-1:0]   r_a1_p1;
    logic                r_rd_vld_p2;
    logic [DATA_W-1:0]   r_mem [RSP_DEPTH];
    logic [PTR_W-1:0]    r_wptr, r_rptr;
    logic [CNT_FW-1:0]   r_count;
    logic [CNT_W-1:0]    r_conflict;

    logic                w_wr_acc, w_rd_acc, w_hazard, w_credit_ok;
    logic                w_push, w_pop;
    logic [1:0]          w_inflight;
    logic [CNT_FW:0]     w_used;

    // Both bank ports are registered identically, so a same-address collision
    // can only arise from a write and read accepted in the same cycle.
    assign wr_ready    = ~RST;
    assign w_wr_acc    = wr_valid & wr_ready;
    assign w_hazard    = w_wr_acc & rd_valid & (wr_addr == rd_addr);
    assign w_inflight  = {1'b0, r_ce1_p1} + {1'b0, r_rd_vld_p2};
    assign w_used      = {1'b0, r_count} + {{(CNT_FW - 1){1'b0}}, w_inflight};
    assign w_credit_ok = (w_used < DEPTH_V);
    assign rd_ready    = ~RST & w_credit_ok & ~w_hazard;
    assign w_rd_acc    = rd_valid & rd_ready;

    assign w_push    = r_rd_vld_p2;
    assign rsp_valid = (r_count != '0);
    assign w_pop     = rsp_valid & rsp_ready;
    assign rsp_data  = rsp_valid ? r_mem[r_rptr] : '0;

    assign CE0          = r_ce0_p1;
    assign WE0          = r_we0_p1;
    assign A0           = r_a0_p1;
    assign D0           = r_d0_p1;
    assign WEM0         = r_wem0_p1;
    assign CE1          = r_ce1_p1;
    assign A1           = r_a1_p1;
    assign conflict_cnt = r_conflict;

    // Stage p1: drive an accepted write onto bank port 0; address/data hold when idle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ce0_p1  <= 1'b0;
            r_we0_p1  <= 1'b0;
            r_a0_p1   <= '0;
            r_d0_p1   <= '0;
            r_wem0_p1 <= '0;
        end else begin
            r_ce0_p1 <= w_wr_acc;
            r_we0_p1 <= w_wr_acc;
            if (w_wr_acc) begin
                r_a0_p1   <= wr_addr;
                r_d0_p1   <= wr_data;
                r_wem0_p1 <= wr_mask;
            end
        end
    end

    // Stage p1/p2: drive an accepted read onto bank port 1, then mark Q1 valid
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ce1_p1    <= 1'b0;
            r_a1_p1     <= '0;
            r_rd_vld_p2 <= 1'b0;
        end else begin
            r_ce1_p1    <= w_rd_acc;
            r_rd_vld_p2 <= r_ce1_p1;
            if (w_rd_acc) begin
                r_a1_p1 <= rd_addr;
            end
        end
    end

    // Response FIFO pointers and occupancy; simultaneous push/pop keep count
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= ptr_inc(r_wptr);
            if (w_pop)  r_rptr <= ptr_inc(r_rptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Response FIFO storage; contents are qualified by the occupancy count
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= Q1;
        end
    end

    // Count stalled-read hazard cycles, saturating at all-ones
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_conflict <= '0;
        end else if (w_hazard) begin
            r_conflict <= sat_inc(r_conflict);
        end
    end

    // Credits make a capture into a full FIFO unreachable
    always_ff @(posedge CLK) begin
        if (!RST) begin
            assert (!(w_push && !w_pop && (r_count == FULL_CNT)));
        end
    end

endmodule

// File: tb/tb_slm_bank_access_ctrl.sv
// Self-checking bench for slm_bank_access_ctrl with a behavioural bank model.
module tb_slm_bank_access_ctrl;

    localparam int AW    = 17;
    localparam int DW    = 64;
    localparam int DEPTH = 4;
    localparam int CW    = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] wr_mask = '0;
    logic          rd_valid = 1'b0;
    logic          rd_ready;
    logic [AW-1:0] rd_addr = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic          CE0, WE0, CE1;
    logic [AW-1:0] A0, A1;
    logic [DW-1:0] D0, WEM0;
    logic [DW-1:0] Q1 = '0;
    logic [CW-1:0] conflict_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int viol   = 0;

    logic [DW-1:0] bank [logic [AW-1:0]];
    logic [DW-1:0] got [$];
    int            got_cyc [$];

    slm_bank_access_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .RSP_DEPTH(DEPTH), .CNT_W(CW)
    ) dut (
        .CLK(CLK), .RST(RST),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_mask(wr_mask),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .CE0(CE0), .A0(A0), .D0(D0), .WE0(WE0), .WEM0(WEM0),
        .CE1(CE1), .A1(A1), .Q1(Q1),
        .conflict_cnt(conflict_cnt)
    );

    always #5 CLK = ~CLK;

    function automatic logic [DW-1:0] bank_rd(input logic [AW-1:0] a);
        return bank.exists(a) ? bank[a] : '0;
    endfunction

    // Bank model: read data one cycle after CE1, masked write on CE0&WE0
    always @(posedge CLK) begin
        cyc++;
        if (CE1) Q1 <= bank_rd(A1);
        if (CE0 && WE0) bank[A0] = (bank_rd(A0) & ~WEM0) | (D0 & WEM0);
    end

    // Response and port-collision monitors
    always @(negedge CLK) begin
        if (rsp_valid && rsp_ready) begin
            got.push_back(rsp_data);
            got_cyc.push_back(cyc);
        end
        if (CE0 && CE1 && (A0 == A1)) viol++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
        wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
        @(posedge CLK); #1;
        wr_valid = 1'b0;
        @(negedge CLK);
        check("wr_port", {CE0, WE0, A0, D0, WEM0}, {1'b1, 1'b1, a, d, m});
        @(posedge CLK); #1;
    endtask

    task automatic wait_rd_accept(output int stalls);
        bit done = 1'b0;
        stalls = 0;
        while (!done) begin
            @(negedge CLK);
            if (rd_ready) done = 1'b1;
            else begin
                stalls++;
                if (stalls >= 50) begin
                    check("rd_accept_timeout", 0, 1);
                    done = 1'b1;
                end
            end
        end
        @(posedge CLK); #1;
        rd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat, output logic [DW-1:0] d);
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (!rsp_valid && lat < 30);
        d = rsp_data;
        @(posedge CLK); #1;
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] pre;
        logic [DW-1:0] data;
        logic [DW-1:0] mask;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t          vecs [6];
    int            st, lat, acc, n, bad;
    logic [DW-1:0] d;

    initial begin
        vecs[0] = '{17'h1ABCD, 64'h0, 64'hDEADBEEF_01234567, 64'hFFFFFFFF_FFFFFFFF, 64'hDEADBEEF_01234567};
        vecs[1] = '{17'h00123, 64'hFFFFFFFF_FFFFFFFF, 64'h0, 64'h00000000_0000FF00, 64'hFFFFFFFF_FFFF00FF};
        vecs[2] = '{17'h1FFFF, 64'h01234567_89ABCDEF, 64'hFEDCBA98_76543210, 64'hFFFFFFFF_00000000, 64'hFEDCBA98_89ABCDEF};
        vecs[3] = '{17'h00000, 64'hAAAAAAAA_AAAAAAAA, 64'h55555555_55555555, 64'h0, 64'hAAAAAAAA_AAAAAAAA};
        vecs[4] = '{17'h0F0F0, 64'h0, 64'hFFFFFFFF_FFFFFFFF, 64'h80000000_00000001, 64'h80000000_00000001};
        vecs[5] = '{17'h10000, 64'h11111111_11111111, 64'h22222222_22222222, 64'h0F0F0F0F_0F0F0F0F, 64'h12121212_12121212};

        // Reset state, with requests presented to prove they are refused
        wr_valid = 1'b1; rd_valid = 1'b1; wr_addr = 17'h5; rd_addr = 17'h5;
        repeat (2) @(negedge CLK);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_rd_ready", rd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_ce_we", {CE0, WE0, CE1}, 0);
        check("rst_addr", {A0, A1}, 0);
        check("rst_d_wem", {D0, WEM0}, 0);
        check("rst_conflict", conflict_cnt, 0);
        @(posedge CLK); #1;
        wr_valid = 1'b0; rd_valid = 1'b0;
        RST = 1'b0;
        rsp_ready = 1'b1;
        @(negedge CLK);
        check("rdy_after_reset", {wr_ready, rd_ready}, 2'b11);
        @(posedge CLK); #1;

        // Table-driven write / masked write / read-back
        for (int i = 0; i < 6; i++) begin
            do_write(vecs[i].addr, vecs[i].pre, 64'hFFFFFFFF_FFFFFFFF);
            do_write(vecs[i].addr, vecs[i].data, vecs[i].mask);
            rd_addr = vecs[i].addr; rd_valid = 1'b1;
            wait_rd_accept(st);
            wait_rsp(lat, d);
            check($sformatf("vec%0d_data", i), d, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), lat, 3);
            check($sformatf("vec%0d_wr_hold", i), {CE0, WE0, A0, D0, WEM0},
                  {2'b00, vecs[i].addr, vecs[i].data, vecs[i].mask});
        end

        // Single-cycle same-address hazard
        do_write(17'h00800, 64'h0, 64'hFFFFFFFF_FFFFFFFF);
        check("cnt_before_hazard", conflict_cnt, 0);
        wr_valid = 1'b1; wr_addr = 17'h00800; wr_data = 64'h55; wr_mask = '1;
        rd_valid = 1'b1; rd_addr = 17'h00800;
        @(negedge CLK);
        check("haz_rd_ready", rd_ready, 0);
        @(posedge CLK); #1;
        wr_valid = 1'b0;
        wait_rd_accept(st);
        check("haz_extra_stall", st, 0);
        wait_rsp(lat, d);
        check("haz_data", d, 64'h55);
        check("haz_latency", lat, 3);
        check("haz_cnt", conflict_cnt, 1);

        // Two consecutive hazard cycles; read returns the later write
        n = 0;
        wr_valid = 1'b1; wr_data = 64'h66; rd_valid = 1'b1;
        @(negedge CLK); if (!rd_ready) n++;
        @(posedge CLK); #1;
        wr_data = 64'h77;
        @(negedge CLK); if (!rd_ready) n++;
        @(posedge CLK); #1;
        wr_valid = 1'b0;
        wait_rd_accept(st);
        wait_rsp(lat, d);
        check("haz2_stalls", n, 2);
        check("haz2_data", d, 64'h77);
        check("haz2_cnt", conflict_cnt, 3);

        // Long hazard run drives the counter into saturation
        n = 0;
        rd_valid = 1'b1; rd_addr = 17'h00300;
        for (int k = 0; k < 20; k++) begin
            wr_valid = 1'b1; wr_addr = 17'h00300; wr_data = 64'h100 + 64'(k); wr_mask = '1;
            @(negedge CLK); if (!rd_ready) n++;
            @(posedge CLK); #1;
        end
        wr_valid = 1'b0;
        wait_rd_accept(st);
        wait_rsp(lat, d);
        check("sat_stalls", n, 20);
        check("sat_cnt", conflict_cnt, 4'hF);
        check("sat_data", d, 64'h113);

        // Backpressure: credits cap accepted reads at RSP_DEPTH
        for (int k = 0; k < 6; k++) do_write(17'h00200 + 17'(k), 64'hB000 + 64'(k), '1);
        rsp_ready = 1'b0;
        got.delete(); got_cyc.delete();
        acc = 0;
        for (int k = 0; k < 10; k++) begin
            rd_valid = 1'b1; rd_addr = 17'h00200 + 17'(acc);
            @(negedge CLK); if (rd_ready) acc++;
            @(posedge CLK); #1;
        end
        check("bp_accepted", acc, 4);
        @(negedge CLK);
        check("bp_rd_ready_low", rd_ready, 0);
        @(posedge CLK); #1;
        rsp_ready = 1'b1;
        n = 0;
        while (acc < 6 && n < 30) begin
            rd_valid = 1'b1; rd_addr = 17'h00200 + 17'(acc);
            @(negedge CLK); if (rd_ready) acc++;
            @(posedge CLK); #1;
            n++;
        end
        rd_valid = 1'b0;
        check("bp_all_accepted", acc, 6);
        n = 0;
        while (got.size() < 6 && n < 30) begin @(posedge CLK); n++; end
        #1;
        check("bp_rsp_count", got.size(), 6);
        for (int k = 0; k < got.size(); k++)
            check($sformatf("bp_rsp%0d", k), got[k], 64'hB000 + 64'(k));

        // Streaming: 100 writes then 100 back-to-back reads
        for (int i = 0; i < 100; i++) begin
            wr_valid = 1'b1; wr_addr = 17'(i); wr_data = 64'(i * 3); wr_mask = '1;
            @(posedge CLK); #1;
        end
        wr_valid = 1'b0;
        got.delete(); got_cyc.delete();
        st = 0; acc = 0; n = 0;
        while (acc < 100 && n < 400) begin
            rd_valid = 1'b1; rd_addr = 17'(acc);
            @(negedge CLK);
            if (rd_ready) acc++; else st++;
            @(posedge CLK); #1;
            n++;
        end
        rd_valid = 1'b0;
        n = 0;
        while (got.size() < 100 && n < 50) begin @(posedge CLK); n++; end
        #1;
        check("stream_stalls", st, 0);
        check("stream_count", got.size(), 100);
        bad = 0;
        for (int i = 0; i < got.size(); i++) begin
            if (got[i] !== 64'(i * 3)) bad++;
            if (i > 0 && got_cyc[i] != got_cyc[i-1] + 1) bad++;
        end
        check("stream_values_spacing", bad, 0);
        if (got.size() > 99) check("stream_last", got[99], 64'd297);

        // Reset with 2 reads in flight and 2 FIFO entries
        rsp_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            rd_valid = 1'b1; rd_addr = 17'h00200 + 17'(k);
            @(negedge CLK); if (rd_ready) acc++;
            @(posedge CLK); #1;
        end
        rd_valid = 1'b0;
        check("mid_pre_accepted", acc, 4);
        check("mid_pre_state", {CE1, rsp_valid}, 2'b11);
        #2 RST = 1'b1;
        #1;
        check("mid_rst_outputs", {rsp_valid, CE1, CE0, rd_ready, wr_ready}, 0);
        check("mid_rst_rsp_data", rsp_data, 0);
        @(posedge CLK);
        @(posedge CLK); #1;
        RST = 1'b0;
        rsp_ready = 1'b1;
        got.delete(); got_cyc.delete();
        repeat (6) @(posedge CLK);
        #1;
        check("mid_no_stale", got.size(), 0);
        check("mid_cnt_cleared", conflict_cnt, 0);
        rd_addr = 17'h00203; rd_valid = 1'b1;
        wait_rd_accept(st);
        wait_rsp(lat, d);
        check("mid_new_data", d, 64'hB003);
        check("mid_new_latency", lat, 3);

        check("no_port_collision", viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
